instr_fetch: RTL

Instruction fetch stage directly upstream of the decode/control logic. Holds the program counter, issues one word-aligned request at a time to instruction memory over a valid/ready request channel, and captures the returned word. Presents the instruction, its opcode and its PC to decode with a valid flag. Accepts a one-cycle redirect (taken branch, JAL, JALR) from execute. Honours a stall from downstream.

---
 rtl/instr_fetch.sv | 116 +++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the fetch PC, issues one request at a time to
// instruction memory and holds the returned word for decode until consumed.
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        stall,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [6:0]  opcode,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4
);

   localparam logic [31:0] Nop = 32'h0000_0013;

   typedef enum logic [1:0] {StReq, StWait, StHold} state_e;

   state_e      state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic        drop_q, drop_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_q, pc_d;
   logic        valid_q, valid_d;
   logic [31:0] redirect_aligned;

   assign redirect_aligned = {redirect_pc[31:2], 2'b00};

   always_comb begin
      state_d        = state_q;
      fetch_pc_d     = fetch_pc_q;
      drop_d         = drop_q;
      instr_d        = instr_q;
      pc_d           = pc_q;
      imem_req_valid = 1'b0;
      imem_addr      = fetch_pc_q;

      unique case (state_q)
         StReq: begin
            imem_req_valid = !redirect_valid;
            if (redirect_valid) begin
               fetch_pc_d = redirect_aligned;
            end else if (imem_req_ready) begin
               state_d = StWait;
            end
         end
         StWait: begin
            if (redirect_valid) begin
               fetch_pc_d = redirect_aligned;
               // The in-flight response belongs to the old path: drop it now if it
               // is here, otherwise remember to drop it when it shows up.
               if (imem_rsp_valid) begin
                  drop_d  = 1'b0;
                  state_d = StReq;
               end else begin
                  drop_d = 1'b1;
               end
            end else if (imem_rsp_valid) begin
               if (drop_q) begin
                  drop_d  = 1'b0;
                  state_d = StReq;
               end else begin
                  instr_d = imem_rsp_data;
                  pc_d    = fetch_pc_q;
                  state_d = StHold;
               end
            end
         end
         StHold: begin
            if (redirect_valid) begin
               fetch_pc_d = redirect_aligned;
               state_d    = StReq;
            end else if (!stall) begin
               fetch_pc_d = fetch_pc_q + 32'd4;
               state_d    = StReq;
            end
         end
         default: state_d = StReq;
      endcase

      valid_d = (state_d == StHold);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StReq;
         fetch_pc_q <= RESET_PC;
         drop_q     <= 1'b0;
         instr_q    <= Nop;
         pc_q       <= RESET_PC;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         drop_q     <= drop_d;
         instr_q    <= instr_d;
         pc_q       <= pc_d;
         valid_q    <= valid_d;
      end
   end

   assign instr_valid = valid_q;
   assign instr       = instr_q;
   assign opcode      = instr_q[6:0];
   assign pc          = pc_q;
   assign pc_plus4    = pc_q + 32'd4;

endmodule
